// File: rtl/spi_slave_sync.sv
// spi_slave_sync: system-clock SPI slave (any CPOL/CPHA) with a one-word tx buffer and rx strobe
// Define SPI_SLAVE_TRISTATE_EN to float MISO outside a frame; otherwise MISO is driven 0 there.
module spi_slave_sync #(
  parameter int DATA_W = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter bit MSB_FIRST = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              MOSI,
  output logic              MISO
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q, vld_q;
  logic sclk_p, cs_p, armed;
  logic sclk_s, cs_s, mosi_s, lead, trail, samp, shft, cs_fall, last, load, tx_bit;
  logic [DATA_W-1:0] tx_sh, rx_sh, rx_nx, tx_nx, buf_q;
  logic buf_full, reload_pend, hold, drv;
  logic [CW-1:0] bit_cnt;
  always_ff @(posedge clk)
    if (reset) begin
      sclk_q <= {SYNC_STAGES{CPOL}};
      cs_q <= '1;
      mosi_q <= '0;
      vld_q <= '0;
      sclk_p <= CPOL;
      cs_p <= 1'b1;
      armed <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
      cs_q <= {cs_q[SYNC_STAGES-2:0], CS};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
      vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_p <= sclk_s;
      cs_p <= cs_s;
      armed <= armed | (vld_q[SYNC_STAGES-1] & cs_s);
    end
  // armed blocks a frame already in progress at reset release: CS must be seen high first
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign lead = (sclk_p == CPOL) & (sclk_s != CPOL);
  assign trail = (sclk_p != CPOL) & (sclk_s == CPOL);
  assign samp = CPHA ? trail : lead;
  assign shft = CPHA ? lead : trail;
  assign cs_fall = armed & cs_p & ~cs_s;
  assign last = bit_cnt == CW'(DATA_W-1);
  assign rx_nx = MSB_FIRST ? {rx_sh[DATA_W-2:0], mosi_s} : {mosi_s, rx_sh[DATA_W-1:1]};
  assign tx_nx = MSB_FIRST ? {tx_sh[DATA_W-2:0], 1'b0} : {1'b0, tx_sh[DATA_W-1:1]};
  assign tx_bit = MSB_FIRST ? tx_sh[DATA_W-1] : tx_sh[0];
  always_comb begin
    state_n = (state == IDLE) ? (cs_fall ? ACTIVE : IDLE) : (cs_s ? IDLE : ACTIVE);
    load = (state == IDLE) ? cs_fall : (shft & reload_pend & ~cs_s);
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      tx_sh <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_underrun <= 1'b0;
      buf_q <= '0;
      buf_full <= 1'b0;
      reload_pend <= 1'b0;
      hold <= 1'b0;
      drv <= 1'b0;
      bit_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      tx_underrun <= load & ~buf_full;
      buf_full <= (buf_full & ~load) | (tx_valid & ~buf_full);
      if (tx_valid & ~buf_full) buf_q <= tx_data;
      if (load) tx_sh <= buf_full ? buf_q : '0;
      if (state == IDLE) begin
        bit_cnt <= '0;
        reload_pend <= 1'b0;
        hold <= CPHA;
        drv <= !CPHA;
      end else begin
        if (samp) begin
          rx_sh <= rx_nx;
          bit_cnt <= last ? '0 : bit_cnt + 1'b1;
          if (last) begin
            rx_data <= rx_nx;
            rx_valid <= 1'b1;
            reload_pend <= 1'b1;
          end
        end
        // with CPHA=1 the first leading edge only starts driving the already loaded bit
        if (shft & ~cs_s) begin
          drv <= 1'b1;
          hold <= 1'b0;
          if (reload_pend) reload_pend <= 1'b0;
          else if (!hold) tx_sh <= tx_nx;
        end
        if (cs_s) begin
          bit_cnt <= '0;
          reload_pend <= 1'b0;
        end
      end
    end
  assign tx_ready = ~buf_full;
  assign busy = state == ACTIVE;
`ifdef SPI_SLAVE_TRISTATE_EN
  assign MISO = (busy & ~reset) ? (drv & tx_bit) : 1'bz;
`else
  assign MISO = busy & ~reset & drv & tx_bit;
`endif
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: drives a mode-0 LSB-first slave and a mode-3 MSB-first slave from a bit-level SPI master model
module tb_spi_slave_sync;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] tx_data[2], rx_data[2];
  logic tx_valid[2], tx_ready[2], rx_valid[2], tx_underrun[2], busy[2];
  logic sclk[2], cs[2], mosi[2], miso[2];
  logic [7:0] txw[4], mo_w[4], mi_w[4];
  logic [7:0] rxw[2][16];
  int nrx[2] = '{0, 0};
  int nur[2] = '{0, 0};
  int vecs = 0, fails = 0;

  always #5 clk = ~clk;

  spi_slave_sync d0 (
    .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .tx_underrun(tx_underrun[0]), .busy(busy[0]),
    .SCLK(sclk[0]), .CS(cs[0]), .MOSI(mosi[0]), .MISO(miso[0])
  );
  spi_slave_sync #(.CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) d3 (
    .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .tx_underrun(tx_underrun[1]), .busy(busy[1]),
    .SCLK(sclk[1]), .CS(cs[1]), .MOSI(mosi[1]), .MISO(miso[1])
  );

  always @(negedge clk)
    for (int m = 0; m < 2; m++) begin
      if (rx_valid[m]) begin
        rxw[m][nrx[m] % 16] = rx_data[m];
        nrx[m]++;
      end
      if (tx_underrun[m]) nur[m]++;
    end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic push(input int m, input logic [7:0] v);
    int t = 0;
    tx_data[m] = v;
    tx_valid[m] = 1'b1;
    while (!tx_ready[m] && t < 400) begin
      @(negedge clk);
      t++;
    end
    vecs++;
    if (tx_ready[m] !== 1'b1) begin
      fails++;
      $display("FAIL push%0d: tx_ready=%b after %0d cycles, required 1", m, tx_ready[m], t);
    end
    @(negedge clk);
    tx_valid[m] = 1'b0;
  endtask

  task automatic cs_low(input int m);
    cs[m] = 1'b0;
    repeat (16) @(negedge clk);
    vecs++;
    if (busy[m] !== 1'b1) begin
      fails++;
      $display("FAIL busy_on%0d: busy=%b, required 1", m, busy[m]);
    end
  endtask

  task automatic cs_high(input int m);
    repeat (16) @(negedge clk);
    cs[m] = 1'b1;
    repeat (16) @(negedge clk);
    vecs++;
    if (busy[m] !== 1'b0) begin
      fails++;
      $display("FAIL busy_off%0d: busy=%b, required 0", m, busy[m]);
    end
  endtask

  // bit i of the frame: word i/8, LSB-first for slave 0, MSB-first for slave 1
  task automatic spi_bit(input int m, input int i);
    int w = i / 8;
    int b = (m == 0) ? i % 8 : 7 - i % 8;
    if (m == 0) begin
      mosi[0] = mo_w[w][b];
      half();
      mi_w[w][b] = miso[0];
      sclk[0] = 1'b1;
      half();
      sclk[0] = 1'b0;
    end else begin
      sclk[1] = 1'b0;
      mosi[1] = mo_w[w][b];
      half();
      mi_w[w][b] = miso[1];
      sclk[1] = 1'b1;
      half();
    end
  endtask

  // Word loads per frame: mode 0 loads at CS fall and after every completed word;
  // mode 3 loads at CS fall and at the first leading edge of every later word.
  task automatic run_frame(input int m, input int ntx, input int nbits, input string name);
    int rx0 = nrx[m];
    int ur0 = nur[m];
    int nw = nbits / 8;
    int loads = (m == 0) ? 1 + nw : ((nbits + 7) / 8 > 0 ? (nbits + 7) / 8 : 1);
    logic [7:0] exp;
    for (int k = 0; k < 4; k++) mi_w[k] = 8'h00;
    if (ntx > 0) push(m, txw[0]);
    fork
      begin
        cs_low(m);
        for (int i = 0; i < nbits; i++) spi_bit(m, i);
        cs_high(m);
      end
      begin
        for (int k = 1; k < ntx; k++) push(m, txw[k]);
      end
    join
    for (int k = 0; k < nw; k++) begin
      exp = (k < ntx) ? txw[k] : 8'h00;
      vecs++;
      if (mi_w[k] !== exp) begin
        fails++;
        $display("FAIL %s master_rx word%0d: got %h, required %h", name, k, mi_w[k], exp);
      end
      vecs++;
      if (rxw[m][(rx0 + k) % 16] !== mo_w[k]) begin
        fails++;
        $display("FAIL %s rx word%0d: got %h, required %h", name, k, rxw[m][(rx0 + k) % 16], mo_w[k]);
      end
    end
    vecs++;
    if (nrx[m] - rx0 !== nw) begin
      fails++;
      $display("FAIL %s rx_valid pulses: got %0d, required %0d", name, nrx[m] - rx0, nw);
    end
    vecs++;
    if (nur[m] - ur0 !== loads - ntx) begin
      fails++;
      $display("FAIL %s tx_underrun pulses: got %0d, required %0d", name, nur[m] - ur0, loads - ntx);
    end
    vecs++;
    if (tx_ready[m] !== 1'b1) begin
      fails++;
      $display("FAIL %s tx_ready: got %b, required 1", name, tx_ready[m]);
    end
    if (nw > 0) begin
      vecs++;
      if (rx_data[m] !== mo_w[nw-1]) begin
        fails++;
        $display("FAIL %s rx_data: got %h, required %h", name, rx_data[m], mo_w[nw-1]);
      end
    end
  endtask

  task automatic check_idle(input string name);
    for (int m = 0; m < 2; m++) begin
      vecs += 6;
      if (tx_ready[m] !== 1'b1) begin fails++; $display("FAIL %s tx_ready%0d: got %b, required 1", name, m, tx_ready[m]); end
      if (rx_data[m] !== 8'h00) begin fails++; $display("FAIL %s rx_data%0d: got %h, required 00", name, m, rx_data[m]); end
      if (rx_valid[m] !== 1'b0) begin fails++; $display("FAIL %s rx_valid%0d: got %b, required 0", name, m, rx_valid[m]); end
      if (tx_underrun[m] !== 1'b0) begin fails++; $display("FAIL %s tx_underrun%0d: got %b, required 0", name, m, tx_underrun[m]); end
      if (busy[m] !== 1'b0) begin fails++; $display("FAIL %s busy%0d: got %b, required 0", name, m, busy[m]); end
      if (miso[m] !== 1'b0) begin fails++; $display("FAIL %s miso%0d: got %b, required 0", name, m, miso[m]); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    repeat (8) @(negedge clk);
  endtask

  task automatic test_mode0();
    txw[0] = 8'h3C;
    mo_w[0] = 8'hA5;
    run_frame(0, 1, 8, "mode0");
  endtask

  task automatic test_mode3();
    txw[0] = 8'h81;
    mo_w[0] = 8'h7E;
    run_frame(1, 1, 8, "mode3");
  endtask

  task automatic test_back_to_back();
    txw[0] = 8'h11;
    txw[1] = 8'h22;
    mo_w[0] = 8'($urandom);
    mo_w[1] = 8'($urandom);
    run_frame(1, 2, 16, "b2b");
  endtask

  task automatic test_partial();
    mo_w[0] = 8'($urandom);
    run_frame(0, 0, 5, "partial");
    txw[0] = 8'($urandom);
    mo_w[0] = 8'h5A;
    run_frame(0, 1, 8, "after_partial");
  endtask

  task automatic test_underrun();
    mo_w[0] = 8'($urandom);
    run_frame(1, 0, 8, "underrun");
  endtask

  task automatic test_reset_mid();
    int rx0;
    txw[0] = 8'($urandom);
    mo_w[0] = 8'($urandom);
    push(0, txw[0]);
    rx0 = nrx[0];
    cs_low(0);
    for (int i = 0; i < 4; i++) spi_bit(0, i);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset_mid");
    for (int i = 4; i < 8; i++) spi_bit(0, i);
    repeat (16) @(negedge clk);
    vecs += 2;
    if (busy[0] !== 1'b0) begin fails++; $display("FAIL reset_mid ignored frame busy: got %b, required 0", busy[0]); end
    if (nrx[0] != rx0) begin fails++; $display("FAIL reset_mid ignored frame rx_valid pulses: got %0d, required 0", nrx[0] - rx0); end
    cs[0] = 1'b1;
    repeat (32) @(negedge clk);
    txw[0] = 8'($urandom);
    mo_w[0] = 8'($urandom);
    run_frame(0, 1, 8, "post_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      txw[0] = 8'($urandom);
      txw[1] = 8'($urandom);
      mo_w[0] = 8'($urandom);
      mo_w[1] = 8'($urandom);
      if (n % 2 == 0) run_frame(0, 1, 8, "rand_m0");
      else run_frame(1, $urandom_range(0, 2), 16, "rand_m3");
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      tx_data[m] = 8'h00;
      tx_valid[m] = 1'b0;
      cs[m] = 1'b1;
      mosi[m] = 1'b0;
    end
    sclk[0] = 1'b0;
    sclk[1] = 1'b1;
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_partial();
    test_underrun();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Parametrised SPI slave that runs entirely on the system clock. SCLK, CS and MOSI are treated as asynchronous inputs and oversampled.
- Supports all four CPOL/CPHA modes, configurable word width and bit order, and continuous multi-word frames under a single CS assertion.
- Transmit data arrives through a one-word buffer with a valid/ready handshake; each received word is presented with a one-cycle valid strobe.
- Sits between the SPI pins and the register/bus logic of the peripheral.

Parameters:
DATA_W, 8, word width in bits (>=2)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 0, 0 = LSB shifted first, 1 = MSB first
SYNC_STAGES, 2, synchroniser depth on SCLK/CS/MOSI (>=2)

Ports:
clk  in  1  system clock; all state on posedge
reset  in  1  synchronous, active-high reset
tx_data  in  DATA_W  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  tx buffer empty; tx_valid & tx_ready = accept
rx_data  out  DATA_W  last complete received word
rx_valid  out  1  one-cycle pulse when rx_data updates
tx_underrun  out  1  one-cycle pulse when a word load finds tx buffer empty
busy  out  1  synchronised CS low (frame active)
SCLK  in  1  SPI clock, asynchronous
CS  in  1  chip select, active low, asynchronous
MOSI  in  1  master data, asynchronous
MISO  out  1  slave data

Behaviour:
- Clocking: clk is one clock, sampled on posedge. Reset is synchronous and active-high. Required f_clk >= 8 x f_SCLK.
- Synchroniser reset values: SCLK chain = CPOL, CS chain = 1, MOSI chain = 0.
- Edge detect: compares the last two synchronised SCLK samples. Leading edge = idle->active level; trailing edge = active->idle.
  - Sample edge = leading if CPHA=0, else trailing.
  - Shift edge = the opposite edge.
  - Pin-to-detect latency: SYNC_STAGES+1 cycles.
- Reset values: tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0, MISO per the Optional Feature, tx buffer empty, shift registers 0, bit_cnt=0, state IDLE.
- TX buffer: one word deep.
  - Accepts on tx_valid & tx_ready; tx_ready=0 from the next cycle until the buffer is consumed.
  - Loads are decided on the registered buffer state, with no bypass: a handshake in the same cycle as a word load goes into the buffer for the following word.
- State IDLE (CS high):
  - Ignores SCLK edges.
  - On synchronised CS falling: load tx_sh from the buffer (buffer -> empty, tx_ready=1 next cycle).
  - If the buffer is empty: load zeros and pulse tx_underrun.
  - Go to ACTIVE; bit_cnt=0.
- State ACTIVE:
  - Sample edge: shift synchronised MOSI into rx_sh (LSB-first: into the MSB end, shift right; MSB-first: into the LSB end, shift left); bit_cnt++.
  - Shift edge: advance tx_sh by one; MISO presents the next bit.
  - CPHA=0: the first bit is on MISO from the cycle after the CS-fall load. CPHA=1: the first bit is driven at the first leading edge.
  - Word boundary (sample edge with bit_cnt=DATA_W-1):
    - rx_data <= completed word; rx_valid pulses the next cycle; bit_cnt=0.
    - tx_sh reloads from the buffer (or zeros + tx_underrun) at the next shift edge (CPHA=0) or leading edge (CPHA=1).
  - rx has no backpressure: an un-consumed rx_data is overwritten.
- CS rising (synchronised), any time:
  - Go to IDLE.
  - Partial rx word is discarded with no rx_valid; partial tx word is lost.
  - Buffer contents are kept; bit_cnt=0.
- CS rising in the same cycle as a word-completing sample edge: the word completes (rx_valid pulses), then IDLE.
- Reset mid-frame: everything returns to reset values. The frame in progress is ignored until CS is seen high, then low again.
- busy = (state == ACTIVE).

Optional Feature:
- Macro SPI_SLAVE_TRISTATE_EN.
- Defined: MISO = 1'bz whenever in reset or state IDLE; driven only in ACTIVE.
- Undefined: MISO is driven 0 in reset and IDLE (for boards without a shared MISO line). Other behaviour is identical.

Test Plan:
- Mode 0, defaults: load tx 0x3C, CS low, master shifts 0xA5 LSB-first -> master receives 0x3C; rx_data=0xA5 with one rx_valid pulse; tx_ready returns to 1 after the CS fall.
- Mode 3 (CPOL=1, CPHA=1), MSB_FIRST=1: tx 0x81, master sends 0x7E -> master receives 0x81; rx_data=0x7E.
- One CS frame of 16 SCLKs, tx 0x11 then 0x22 (the second is written after the first tx_ready) -> master gets 0x11, 0x22; two rx_valid pulses; tx_underrun never asserted.
- CS raised after 5 bits, then a full frame with 0x5A -> no rx_valid for the partial word; next rx_data=0x5A.
- No tx write before CS fall -> tx_underrun pulses once; master receives 0x00.
- reset asserted at bit 4 of a frame, CS held low, then re-cycled -> outputs at reset values; next full frame transfers correctly.
